// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - pushbutton debouncer: 2-FF sync, stability counter, 4-state FSM
// Define DEBOUNCE_TOGGLE_EN to make d_o toggle on each accepted press instead of following the level.
module button_debounce #(
   parameter int STABLE_CNT = 1000000,
   parameter int CNT_W      = 20
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic d_o,
   output logic pulse_o
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic             s0_q, s1_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             d_q, d_d;
   logic             pulse_q, pulse_d;
   logic             press_accept;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s0_q    <= 1'b0;
         s1_q    <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         d_q     <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         s0_q    <= btn_i;
         s1_q    <= s0_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         pulse_q <= pulse_d;
      end
   end

   // Any sample disagreeing with the level under qualification restarts from the stable state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (s1_q) begin
               state_d = PRESS_CHK;
               cnt_d   = '0;
            end
         end
         PRESS_CHK: begin
            if (!s1_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (!s1_q) begin
               state_d = RELEASE_CHK;
               cnt_d   = '0;
            end
         end
         RELEASE_CHK: begin
            if (s1_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      press_accept = (state_q == PRESS_CHK) && (state_d == HELD);
      pulse_d      = press_accept;
`ifdef DEBOUNCE_TOGGLE_EN
      d_d          = press_accept ? ~d_q : d_q;
`else
      d_d          = (state_d == HELD) || (state_d == RELEASE_CHK);
`endif
   end

   assign d_o     = d_q;
   assign pulse_o = pulse_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - randomized bench for button_debounce against a run-length reference model
module tb_button_debounce;

   localparam int STABLE_CNT = 4;
   localparam int CNT_W      = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn = 1'b1;
   logic d, pulse;

   int n_checks = 0;
   int n_errors = 0;

   button_debounce #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .btn_i   (btn),
      .d_o     (d),
      .pulse_o (pulse)
   );

   always #5 clk = ~clk;

   // Reference: the synchronised level must disagree with the accepted level on
   // STABLE_CNT+1 consecutive edges before the accepted level flips.
   logic m_p0 = 1'b0, m_p1 = 1'b0, m_lvl = 1'b0, m_pulse = 1'b0, m_tog = 1'b0;
   int   m_run = 0, m_edge = 0, m_pcnt = 0;

   always @(posedge clk) begin
      logic seen;
      m_edge = m_edge + 1;
      if (rst) begin
         m_p0 = 1'b0; m_p1 = 1'b0; m_lvl = 1'b0; m_pulse = 1'b0; m_tog = 1'b0; m_run = 0;
      end else begin
         seen    = m_p1;
         m_p1    = m_p0;
         m_p0    = btn;
         m_pulse = 1'b0;
         if (seen != m_lvl) begin
            m_run = m_run + 1;
            if (m_run == STABLE_CNT + 1) begin
               m_lvl = seen;
               m_run = 0;
               if (seen) begin
                  m_pulse = 1'b1;
                  m_tog   = ~m_tog;
                  m_pcnt  = m_pcnt + 1;
               end
            end
         end else begin
            m_run = 0;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s @edge %0d: got %0d expected %0d", tag, m_edge, got, exp);
      end
   endtask

   logic d_prev = 1'b0;
   int   last_rise = -1, last_fall = -1, dut_pcnt = 0;

   task automatic tick(input logic b, input logic r);
      logic exp_d;
      @(negedge clk);
`ifdef DEBOUNCE_TOGGLE_EN
      exp_d = m_tog;
`else
      exp_d = m_lvl;
`endif
      check_eq("d", 32'(d), 32'(exp_d));
      check_eq("pulse", 32'(pulse), 32'(m_pulse));
      if (pulse === 1'b1) dut_pcnt = dut_pcnt + 1;
      if (d === 1'b1 && d_prev === 1'b0) last_rise = m_edge;
      if (d === 1'b0 && d_prev === 1'b1) last_fall = m_edge;
      d_prev = d;
      btn = b;
      rst = r;
   endtask

   task automatic hold(input logic b, input int n);
      for (int i = 0; i < n; i++) tick(b, 1'b0);
   endtask

   initial begin
      int start;
      logic lvl;
      // reset with the button held
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      hold(1'b0, 8);

      // clean press: first sampled at edge start, accepted STABLE_CNT+2 edges later
      last_rise = -1;
      tick(1'b1, 1'b0);
      start = m_edge + 1;
      hold(1'b1, 19);
      check_eq("rise_latency", 32'(last_rise - start), 32'(STABLE_CNT + 2));
      last_fall = -1;
      tick(1'b0, 1'b0);
      start = m_edge + 1;
      hold(1'b0, 14);
`ifndef DEBOUNCE_TOGGLE_EN
      check_eq("fall_latency", 32'(last_fall - start), 32'(STABLE_CNT + 2));
`endif

      // press bounce
      hold(1'b1, 3); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 1);
      hold(1'b1, 12); hold(1'b0, 12);

      // release bounce from HELD
      hold(1'b1, 12); hold(1'b0, 3); hold(1'b1, 10); hold(1'b0, 12);

      // reset during press qualification with the button still held
      hold(1'b1, 4);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      hold(1'b1, 12); hold(1'b0, 12);

      // random bounce segments with occasional reset
      lvl = 1'b0;
      for (int s = 0; s < 80; s++) begin
         lvl = ~lvl;
         if ($urandom_range(0, 19) == 0) tick(lvl, 1'b1);
         hold(lvl, int'($urandom_range(1, 9)));
      end
      hold(1'b0, 12);

      check_eq("pulse_count", 32'(dut_pcnt), 32'(m_pcnt));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
